window_spill_ctrl: RTL and testbench
====================================

WINDOW_SPILL_CTRL -- requirements
Module: window_spill_ctrl

Interface
REQ-001 The block SHALL have parameter NWINDOWS, default 8, meaning the number of register windows (2..32).
REQ-002 The block SHALL have parameter WORD_W, default 32, meaning the register, memory data and address width.
REQ-003 The block SHALL have clk  in  1  the single clock; all state updates on the posedge.
REQ-004 The block SHALL have reset  in  1  the asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have save_req, restore_req  in  1 each  SAVE or RESTORE request, accepted only while req_ready=1.
REQ-006 The block SHALL have req_ready  out  1  high only in IDLE.
REQ-007 The block SHALL have done  out  1  one-cycle pulse when an accepted operation completes.
REQ-008 The block SHALL have cwp_in  in  5  current window pointer; wim_in  in  32  window invalid mask; sp_in  in  WORD_W  spill/fill base byte address. All three are sampled at acceptance.
REQ-009 The block SHALL have cwp_inc, cwp_dec  out  1 each  one-cycle pulses that step CWP in the register file.
REQ-010 The block SHALL have wim_wr_en  out  1 and wim_wr_data  out  32, a one-cycle WIM write.
REQ-011 The block SHALL have rf_rd_addr  out  9  physical register index; rf_rd_data  in  WORD_W  read data, valid the cycle after the address is driven.
REQ-012 The block SHALL have rf_wr_en  out  1; rf_wr_addr  out  9; rf_wr_data  out  WORD_W  physical register write port.
REQ-013 The block SHALL have mem_req  out  1; mem_we  out  1; mem_addr  out  WORD_W; mem_wdata  out  WORD_W; mem_ready  in  1; mem_rdata  in  WORD_W  memory port (rdata valid with ready).

Function
REQ-014 The FSM SHALL use the states IDLE, CHECK, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WR, WIM_UPD, STEP and DONE.
REQ-015 In IDLE, save_req=1 SHALL be accepted and take priority; restore_req in the same cycle SHALL be dropped, not queued.
REQ-016 On acceptance the block SHALL latch the operation, cwp_in, wim_in and sp_in, and go to CHECK in the next cycle.
REQ-017 CHECK on SAVE: target W=(cwp-1) mod NWINDOWS; if WIM[W]=0 go to STEP, else go to SPILL_RD with k=0.
REQ-018 CHECK on RESTORE: target W=(cwp+1) mod NWINDOWS; if WIM[W]=0 go to STEP, else go to FILL_REQ with k=0.
REQ-019 The physical index SHALL be W*16+k (k=0..15); the memory address SHALL be sp+4*k, modulo 2^WORD_W.
REQ-020 SPILL_RD SHALL drive rf_rd_addr=W*16+k for one cycle, then go to SPILL_WR.
REQ-021 SPILL_WR SHALL hold mem_req=1, mem_we=1, mem_addr and mem_wdata=rf_rd_data (captured on entry) stable until mem_ready=1; on ready: k++, and if k was 15 go to WIM_UPD, else go to SPILL_RD.
REQ-022 FILL_REQ SHALL hold mem_req=1, mem_we=0 and mem_addr stable until mem_ready=1, capture mem_rdata, then go to FILL_WR.
REQ-023 FILL_WR SHALL pulse rf_wr_en with rf_wr_addr=W*16+k and the captured data for one cycle; k++, and if k was 15 go to WIM_UPD, else go to FILL_REQ.
REQ-024 WIM_UPD SHALL pulse wim_wr_en with a one-hot wim_wr_data at bit (W-1) mod NWINDOWS for SAVE or (W+1) mod NWINDOWS for RESTORE; bits ≥NWINDOWS SHALL be 0.
REQ-025 STEP SHALL pulse cwp_dec for SAVE or cwp_inc for RESTORE, then go to DONE.
REQ-026 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-027 No-spill latency: accept at cycle T → CHECK at T+1 → cwp pulse at T+2 → done at T+3 → req_ready high at T+4.
REQ-028 Mod arithmetic SHALL wrap correctly at both ends (cwp=0 SAVE → W=NWINDOWS-1; cwp=NWINDOWS-1 RESTORE → W=0).
REQ-029 mem_req SHALL never be deasserted, nor its address or data changed, while it is pending unacknowledged.
REQ-030 Outputs not described for the current state SHALL be 0.

Reset
REQ-031 While reset=0, the block SHALL immediately force IDLE with k=0, all pulses and mem_req at 0, all address and data outputs at 0, and req_ready=1.
REQ-032 Reset asserted mid-spill or mid-fill SHALL abandon the operation, with no further RF, WIM or CWP writes and no done pulse.

Verification
REQ-033 NWINDOWS=8, cwp=3, wim=0x01, SAVE → cwp_dec at T+2, done at T+3, no mem_req and no wim_wr_en.
REQ-034 cwp=1, wim=0x01, sp=0x1000, SAVE, mem_ready tied 1 → 16 writes to 0x1000..0x103C of RF[0..15], then wim_wr_data=0x80, then cwp_dec, then done.
REQ-035 cwp=6, wim=0x80, sp=0x2000, RESTORE, mem_ready delayed 3 cycles per access → address stays stable; RF[112..127] receive mem data; wim_wr_data=0x01; cwp_inc.
REQ-036 save_req and restore_req both 1 in IDLE → only the SAVE executes; one done pulse.
REQ-037 reset driven 0 at k=7 of a spill → outputs go to 0 immediately and no done; after release, a new SAVE completes normally.

Source files
------------

// File: rtl/window_spill_ctrl_if.sv
// ============================================================================
// window_spill_ctrl_if : request, register-file, WIM/CWP and memory signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface window_spill_ctrl_if #(
  parameter int WORD_W = 32
);
  logic              save_req;
  logic              restore_req;
  logic              req_ready;
  logic              done;
  logic [4:0]        cwp_in;
  logic [31:0]       wim_in;
  logic [WORD_W-1:0] sp_in;
  logic              cwp_inc;
  logic              cwp_dec;
  logic              wim_wr_en;
  logic [31:0]       wim_wr_data;
  logic [8:0]        rf_rd_addr;
  logic [WORD_W-1:0] rf_rd_data;
  logic              rf_wr_en;
  logic [8:0]        rf_wr_addr;
  logic [WORD_W-1:0] rf_wr_data;
  logic              mem_req;
  logic              mem_we;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    input  save_req, restore_req, cwp_in, wim_in, sp_in, rf_rd_data, mem_ready, mem_rdata,
    output req_ready, done, cwp_inc, cwp_dec, wim_wr_en, wim_wr_data,
           rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output save_req, restore_req, cwp_in, wim_in, sp_in, rf_rd_data, mem_ready, mem_rdata,
    input  req_ready, done, cwp_inc, cwp_dec, wim_wr_en, wim_wr_data,
           rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/window_spill_ctrl.sv
// ============================================================================
// window_spill_ctrl : SAVE/RESTORE register-window spill and fill sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module window_spill_ctrl #(
  parameter int NWINDOWS = 8,
  parameter int WORD_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  window_spill_ctrl_if.master bus
);

  localparam logic [4:0] LAST = 5'(NWINDOWS - 1);

  typedef enum logic [3:0] {
    IDLE, CHECK, SPILL_RD, SPILL_WR, FILL_REQ, FILL_WR, WIM_UPD, STEP, DONE
  } state_t;

  state_t            state;
  logic              is_save;
  logic [4:0]        cwp_q;
  logic [31:0]       wim_q;
  logic [WORD_W-1:0] sp_q;
  logic [4:0]        win;
  logic [3:0]        k;
  logic [WORD_W-1:0] spill_data;
  logic              captured;
  logic [4:0]        target;
  logic [4:0]        wim_bit;
  logic [31:0]       wim_onehot;

  function automatic logic [4:0] wrap_dec(input logic [4:0] v);
    return (v == 5'd0) ? LAST : v - 5'd1;
  endfunction

  function automatic logic [4:0] wrap_inc(input logic [4:0] v);
    return (v >= LAST) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [WORD_W-1:0] slot_addr(input logic [WORD_W-1:0] base,
                                                  input logic [3:0] idx);
    return base + WORD_W'({idx, 2'b00});
  endfunction

  always_comb begin
    target     = is_save ? wrap_dec(cwp_q) : wrap_inc(cwp_q);
    wim_bit    = is_save ? wrap_dec(win) : wrap_inc(win);
    wim_onehot = 32'd1 << wim_bit;
  end

  // RF read data arrives in the first SPILL_WR cycle, so it is forwarded
  // then and held from the capture register afterwards.
  assign bus.mem_wdata = (state == SPILL_WR) ? (captured ? spill_data : bus.rf_rd_data)
                                             : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      is_save         <= 1'b0;
      cwp_q           <= '0;
      wim_q           <= '0;
      sp_q            <= '0;
      win             <= '0;
      k               <= '0;
      spill_data      <= '0;
      captured        <= 1'b0;
      bus.req_ready   <= 1'b1;
      bus.done        <= 1'b0;
      bus.cwp_inc     <= 1'b0;
      bus.cwp_dec     <= 1'b0;
      bus.wim_wr_en   <= 1'b0;
      bus.wim_wr_data <= '0;
      bus.rf_rd_addr  <= '0;
      bus.rf_wr_en    <= 1'b0;
      bus.rf_wr_addr  <= '0;
      bus.rf_wr_data  <= '0;
      bus.mem_req     <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
    end else begin
      bus.done        <= 1'b0;
      bus.cwp_inc     <= 1'b0;
      bus.cwp_dec     <= 1'b0;
      bus.wim_wr_en   <= 1'b0;
      bus.wim_wr_data <= '0;
      bus.rf_rd_addr  <= '0;
      bus.rf_wr_en    <= 1'b0;
      bus.rf_wr_addr  <= '0;
      bus.rf_wr_data  <= '0;
      unique case (state)
        IDLE: begin
          if (bus.save_req || bus.restore_req) begin
            is_save       <= bus.save_req;
            cwp_q         <= bus.cwp_in;
            wim_q         <= bus.wim_in;
            sp_q          <= bus.sp_in;
            k             <= '0;
            bus.req_ready <= 1'b0;
            state         <= CHECK;
          end
        end
        CHECK: begin
          win <= target;
          if (!wim_q[target]) begin
            bus.cwp_dec <= is_save;
            bus.cwp_inc <= !is_save;
            state       <= STEP;
          end else if (is_save) begin
            bus.rf_rd_addr <= {target, 4'd0};
            state          <= SPILL_RD;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= sp_q;
            state        <= FILL_REQ;
          end
        end
        SPILL_RD: begin
          captured     <= 1'b0;
          bus.mem_req  <= 1'b1;
          bus.mem_we   <= 1'b1;
          bus.mem_addr <= slot_addr(sp_q, k);
          state        <= SPILL_WR;
        end
        SPILL_WR: begin
          if (!captured) begin
            spill_data <= bus.rf_rd_data;
            captured   <= 1'b1;
          end
          if (bus.mem_ready) begin
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            k            <= k + 4'd1;
            if (k == 4'd15) begin
              bus.wim_wr_en   <= 1'b1;
              bus.wim_wr_data <= wim_onehot;
              state           <= WIM_UPD;
            end else begin
              bus.rf_rd_addr <= {win, k + 4'd1};
              state          <= SPILL_RD;
            end
          end
        end
        FILL_REQ: begin
          if (bus.mem_ready) begin
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.rf_wr_en   <= 1'b1;
            bus.rf_wr_addr <= {win, k};
            bus.rf_wr_data <= bus.mem_rdata;
            state          <= FILL_WR;
          end
        end
        FILL_WR: begin
          k <= k + 4'd1;
          if (k == 4'd15) begin
            bus.wim_wr_en   <= 1'b1;
            bus.wim_wr_data <= wim_onehot;
            state           <= WIM_UPD;
          end else begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= slot_addr(sp_q, k + 4'd1);
            state        <= FILL_REQ;
          end
        end
        WIM_UPD: begin
          bus.cwp_dec <= is_save;
          bus.cwp_inc <= !is_save;
          state       <= STEP;
        end
        STEP: begin
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_window_spill_ctrl.sv
// ============================================================================
// tb_window_spill_ctrl : table, corner-case and random checks against a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_window_spill_ctrl;
  localparam int NW = 8;
  localparam int WW = 32;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;
  typedef struct { logic [8:0] addr; logic [31:0] data; } rfw_t;
  typedef struct {
    bit s; bit r; int cwp; logic [31:0] wim; logic [31:0] sp; int lat;
    bit spill; int w; logic [31:0] wimd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mem_lat = 0;

  logic [31:0] rf_mem [0:511];
  logic [31:0] ref_rf [0:511];
  mem_t act_mem[$], exp_mem[$];
  rfw_t act_rf[$], exp_rf[$];
  logic [31:0] act_wim[$];
  int act_cwp[$], act_cwp_cyc[$], act_done[$], act_ready[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  window_spill_ctrl_if #(.WORD_W(WW)) bus ();
  window_spill_ctrl #(.NWINDOWS(NW), .WORD_W(WW)) dut (.clk(clk), .reset(reset), .bus(bus));

  function automatic logic [31:0] rf_init(input int i);
    return 32'hC0DE_0000 + 32'(i * 7);
  endfunction

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Synchronous-read register file: data follows the address by one cycle.
  always @(posedge clk) bus.rf_rd_data <= rf_mem[bus.rf_rd_addr];

  // Memory responder with programmable wait cycles and hold checking.
  int   m_cnt = 0;
  bit   m_pend = 0, m_hold_bad = 0;
  mem_t m_first;
  always @(negedge clk) begin
    if (!reset) begin
      bus.mem_ready = 1'b0; m_cnt = 0; m_pend = 0;
    end else if (bus.mem_ready) begin
      bus.mem_ready = 1'b0; m_cnt = 0; m_pend = 0;
    end else if (bus.mem_req) begin
      if (!m_pend) begin
        m_pend = 1; m_hold_bad = 0;
        m_first = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
      end else if (bus.mem_we !== m_first.we || bus.mem_addr !== m_first.addr ||
                   bus.mem_wdata !== m_first.data) begin
        m_hold_bad = 1;
      end
      if (m_cnt == mem_lat) begin
        chk("mem held stable while pending", m_hold_bad, 0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata_of(bus.mem_addr);
        act_mem.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
      end else m_cnt++;
    end else if (m_pend) begin
      chk("mem_req kept while pending", bus.mem_req, 1);
      m_pend = 0;
    end
  end

  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.rf_wr_en) begin
        act_rf.push_back('{bus.rf_wr_addr, bus.rf_wr_data});
        rf_mem[bus.rf_wr_addr] = bus.rf_wr_data;
      end
      if (bus.wim_wr_en) act_wim.push_back(bus.wim_wr_data);
      if (bus.cwp_dec) begin act_cwp.push_back(-1); act_cwp_cyc.push_back(cyc); end
      if (bus.cwp_inc) begin act_cwp.push_back(1);  act_cwp_cyc.push_back(cyc); end
      if (bus.done) act_done.push_back(cyc);
      if (bus.req_ready && !prev_ready) act_ready.push_back(cyc);
    end
    prev_ready = bus.req_ready;
  end

  // Reference: what a whole operation must produce, from the window rules.
  task automatic model_op(input bit s, input int cwp, input logic [31:0] wim,
                          input logic [31:0] sp, input int lat, output bit spill,
                          output int w, output logic [31:0] wimd, output int off);
    logic [31:0] a;
    w     = s ? (cwp + NW - 1) % NW : (cwp + 1) % NW;
    spill = wim[w];
    wimd  = 32'd1 << (s ? (w + NW - 1) % NW : (w + 1) % NW);
    exp_mem.delete(); exp_rf.delete();
    if (spill) begin
      for (int i = 0; i < 16; i++) begin
        a = sp + 32'(4 * i);
        if (s) exp_mem.push_back('{1'b1, a, ref_rf[w * 16 + i]});
        else begin
          exp_mem.push_back('{1'b0, a, 32'd0});
          exp_rf.push_back('{9'(w * 16 + i), rdata_of(a)});
          ref_rf[w * 16 + i] = rdata_of(a);
        end
      end
    end
    off = spill ? 4 + 16 * (lat + 2) : 3;
  endtask

  task automatic clear_logs();
    act_mem.delete(); act_rf.delete(); act_wim.delete();
    act_cwp.delete(); act_cwp_cyc.delete(); act_done.delete(); act_ready.delete();
  endtask

  task automatic run_op(input bit s, input bit r, input int cwp, input logic [31:0] wim,
                        input logic [31:0] sp, input int lat, output bit spill);
    int t0, w, off, guard;
    logic [31:0] wimd;
    mem_lat = lat;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 100) begin @(negedge clk); guard++; end
    chk("req_ready before op", bus.req_ready, 1);
    clear_logs();
    bus.save_req = s; bus.restore_req = r;
    bus.cwp_in = 5'(cwp); bus.wim_in = wim; bus.sp_in = sp;
    t0 = cyc;
    @(negedge clk);
    bus.save_req = 0; bus.restore_req = 0;
    bus.cwp_in = '0; bus.wim_in = '0; bus.sp_in = '0;
    guard = 0;
    while (act_done.size() == 0 && guard < 400) begin @(negedge clk); guard++; end
    repeat (2) @(negedge clk);
    model_op(s, cwp, wim, sp, lat, spill, w, wimd, off);
    chk("done pulse count", act_done.size(), 1);
    if (act_done.size() > 0) chk("done cycle after accept", act_done[0] - t0, off);
    chk("req_ready rise count", act_ready.size(), 1);
    if (act_ready.size() > 0) chk("req_ready cycle after accept", act_ready[0] - t0, off + 1);
    chk("cwp pulse count", act_cwp.size(), 1);
    if (act_cwp.size() > 0) begin
      chk("cwp pulse direction", act_cwp[0], s ? -1 : 1);
      chk("cwp pulse cycle", act_cwp_cyc[0] - t0, off - 1);
    end
    chk("mem access count", act_mem.size(), exp_mem.size());
    for (int i = 0; i < act_mem.size() && i < exp_mem.size(); i++) begin
      chk($sformatf("mem%0d we", i), act_mem[i].we, exp_mem[i].we);
      chk($sformatf("mem%0d addr", i), act_mem[i].addr, exp_mem[i].addr);
      chk($sformatf("mem%0d wdata", i), act_mem[i].data, exp_mem[i].data);
    end
    chk("rf write count", act_rf.size(), exp_rf.size());
    for (int i = 0; i < act_rf.size() && i < exp_rf.size(); i++) begin
      chk($sformatf("rf%0d addr", i), act_rf[i].addr, exp_rf[i].addr);
      chk($sformatf("rf%0d data", i), act_rf[i].data, exp_rf[i].data);
    end
    chk("wim write count", act_wim.size(), spill ? 1 : 0);
    if (spill && act_wim.size() > 0) chk("wim write data", act_wim[0], wimd);
  endtask

  vec_t tbl[8];

  initial begin
    bit sp_flag;
    int guard;
    for (int i = 0; i < 512; i++) begin rf_mem[i] = rf_init(i); ref_rf[i] = rf_init(i); end
    bus.save_req = 0; bus.restore_req = 0; bus.cwp_in = '0; bus.wim_in = '0; bus.sp_in = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", bus.req_ready, 1);
    chk("reset done", bus.done, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset cwp pulses", {bus.cwp_inc, bus.cwp_dec}, 0);
    chk("reset wim_wr", {bus.wim_wr_en, bus.wim_wr_data}, 0);
    chk("reset rf ports", {bus.rf_wr_en, bus.rf_wr_addr, bus.rf_rd_addr}, 0);
    reset = 1'b1;

    //          s  r  cwp wim           sp            lat spill w  wimd
    tbl[0] = '{1, 0, 3, 32'h0000_0001, 32'h0000_0000, 0, 0, 2, 32'h00};
    tbl[1] = '{1, 0, 1, 32'h0000_0001, 32'h0000_1000, 0, 1, 0, 32'h80};
    tbl[2] = '{0, 1, 6, 32'h0000_0080, 32'h0000_2000, 3, 1, 7, 32'h01};
    tbl[3] = '{1, 1, 5, 32'h0000_0000, 32'h0000_0000, 0, 0, 4, 32'h00};
    tbl[4] = '{1, 0, 0, 32'h0000_0080, 32'h0000_3000, 1, 1, 7, 32'h40};
    tbl[5] = '{0, 1, 7, 32'h0000_0001, 32'h0000_0400, 0, 1, 0, 32'h02};
    tbl[6] = '{0, 1, 2, 32'h0000_00F7, 32'h0000_0000, 2, 0, 3, 32'h00};
    tbl[7] = '{1, 0, 0, 32'h0000_007F, 32'h0000_0000, 0, 0, 7, 32'h00};
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].s, tbl[i].r, tbl[i].cwp, tbl[i].wim, tbl[i].sp, tbl[i].lat, sp_flag);
      chk($sformatf("tbl%0d mem count", i), act_mem.size(), tbl[i].spill ? 16 : 0);
      chk($sformatf("tbl%0d cwp dir", i), act_cwp.size() > 0 ? act_cwp[0] : 0, tbl[i].s ? -1 : 1);
      if (tbl[i].spill && act_wim.size() > 0)
        chk($sformatf("tbl%0d wim data", i), act_wim[0], tbl[i].wimd);
      if (tbl[i].spill && act_mem.size() == 16) begin
        chk($sformatf("tbl%0d first addr", i), act_mem[0].addr, tbl[i].sp);
        chk($sformatf("tbl%0d last addr", i), act_mem[15].addr, tbl[i].sp + 32'h3C);
      end
      if (tbl[i].spill && !tbl[i].s && act_rf.size() == 16) begin
        chk($sformatf("tbl%0d first rf idx", i), act_rf[0].addr, tbl[i].w * 16);
        chk($sformatf("tbl%0d last rf idx", i), act_rf[15].addr, tbl[i].w * 16 + 15);
      end
    end

    // Reset in the middle of a spill, then a clean operation afterwards.
    mem_lat = 0;
    clear_logs();
    @(negedge clk);
    bus.save_req = 1; bus.cwp_in = 5'd1; bus.wim_in = 32'h1; bus.sp_in = 32'h5000;
    @(negedge clk);
    bus.save_req = 0;
    guard = 0;
    while (act_mem.size() < 7 && guard < 200) begin @(negedge clk); guard++; end
    chk("abort run reached k=7", act_mem.size() >= 7, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort req_ready", bus.req_ready, 1);
    chk("abort mem_req", {bus.mem_req, bus.mem_we}, 0);
    chk("abort mem_addr", bus.mem_addr, 0);
    chk("abort mem_wdata", bus.mem_wdata, 0);
    chk("abort rf ports", {bus.rf_wr_en, bus.rf_wr_addr, bus.rf_rd_addr, bus.rf_wr_data}, 0);
    chk("abort pulses", {bus.done, bus.cwp_inc, bus.cwp_dec, bus.wim_wr_en}, 0);
    clear_logs();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort no done", act_done.size(), 0);
    chk("abort no wim write", act_wim.size(), 0);
    chk("abort no cwp step", act_cwp.size(), 0);
    chk("abort no rf write", act_rf.size(), 0);
    run_op(1, 0, 1, 32'h1, 32'h6000, 1, sp_flag);
    run_op(1, 0, 4, 32'h0, 32'h0, 0, sp_flag);

    for (int n = 0; n < 20; n++) begin
      bit s, r;
      s = 1'($urandom_range(0, 1));
      r = s ? 1'($urandom_range(0, 1)) : 1'b1;
      run_op(s, r, int'($urandom_range(0, NW - 1)), $urandom, $urandom,
             int'($urandom_range(0, 2)), sp_flag);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
